rng_bank: RTL

//   Source end of the node-update random-number interface: supplies one P_OUT-bit

---
 rtl/rbm_rng_pkg.sv | 15 +
 rtl/lfsr_lane.sv | 48 ++++
 rtl/rng_bank.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rbm_rng_pkg.sv
// Shared constants for the RBM random-number source.
//   TAP_MASK_32     : Galois feedback mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED_32 : base reset seed; lane i resets to DEFAULT_SEED_32 + i
//   rng_fsm_t       : bank sequencing states (WARMUP discards words, RUN serves them)
package rbm_rng_pkg;

  localparam logic [31:0] TAP_MASK_32     = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED_32 = 32'hACE1_0001;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } rng_fsm_t;

endpackage

// File: rtl/lfsr_lane.sv
// One seedable Galois LFSR lane.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (state <- RESET_SEED)
//   load      : load load_val this cycle (a zero value is stored as 1)
//   load_val  : seed value
//   step      : advance the LFSR one position
//   state     : current registered LFSR state
//   zero_det  : state is all-zero (illegal lockup state)
// Priority: rst > load > zero recovery > step.
module lfsr_lane #(
  parameter int                 RNG_LEN    = 32,
  parameter logic [RNG_LEN-1:0] TAP_MASK   = RNG_LEN'(32'h8020_0003),
  parameter logic [RNG_LEN-1:0] RESET_SEED = RNG_LEN'(32'hACE1_0001)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [RNG_LEN-1:0] load_val,
  input  logic               step,
  output logic [RNG_LEN-1:0] state,
  output logic               zero_det
);

  localparam logic [RNG_LEN-1:0] ONE       = RNG_LEN'(1);
  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
  localparam logic [RNG_LEN-1:0] SEED_SAFE = (RESET_SEED == '0) ? ONE : RESET_SEED;

  logic [RNG_LEN-1:0] r_state;
  logic [RNG_LEN-1:0] w_step_val;

  assign w_step_val = (r_state >> 1) ^ (r_state[0] ? TAP_MASK : '0);
  assign zero_det   = (r_state == '0);
  assign state      = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED_SAFE;
    end else if (load) begin
      r_state <= (load_val == '0) ? ONE : load_val;
    end else if (zero_det) begin
      // Only an upset can reach zero; recover instead of stepping.
      r_state <= ONE;
    end else if (step) begin
      r_state <= w_step_val;
    end
  end

endmodule

// File: rtl/rng_bank.sv
// Bank of NUM_NODES LFSR lanes feeding the node_update instances.
// After reset or any accepted reseed the bank discards WARMUP_CYCLES steps,
// then presents one P_OUT-bit word per lane under a valid/ready handshake.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   seed_valid  : load seed_data into lane seed_lane (out-of-range lanes ignored)
//   seed_lane   : target lane
//   seed_data   : seed value (zero stored as 1)
//   rand_ready  : consumer accepts the current words
//   rand_valid  : words on rand_data are fresh
//   rand_data   : lane i at [i*P_OUT +: P_OUT], top P_OUT bits of lane state
//   draw_count  : accepted transfers, saturating
//   lockup_err  : sticky flag, some lane was seen in the all-zero state
module rng_bank
  import rbm_rng_pkg::*;
#(
  parameter int                 NUM_NODES     = 3,
  parameter int                 RNG_LEN       = 32,
  parameter int                 P_OUT         = 15,
  parameter logic [RNG_LEN-1:0] TAP_MASK      = RNG_LEN'(TAP_MASK_32),
  parameter logic [RNG_LEN-1:0] DEFAULT_SEED  = RNG_LEN'(DEFAULT_SEED_32),
  parameter int                 WARMUP_CYCLES = 16,
  parameter int                 LANE_W        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid,
  input  logic [LANE_W-1:0]          seed_lane,
  input  logic [RNG_LEN-1:0]         seed_data,
  input  logic                       rand_ready,
  output logic                       rand_valid,
  output logic [NUM_NODES*P_OUT-1:0] rand_data,
  output logic [15:0]                draw_count,
  output logic                       lockup_err
);

  localparam int                  WARM_W      = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [WARM_W-1:0]   WARM_INIT   = WARM_W'(WARMUP_CYCLES);
  localparam logic [LANE_W:0]     NUM_NODES_W = (LANE_W + 1)'(NUM_NODES);

  rng_fsm_t                     r_fsm;
  rng_fsm_t                     w_fsm_next;
  logic [WARM_W-1:0]            r_warm_cnt;
  logic [WARM_W-1:0]            w_warm_next;
  logic [15:0]                  r_draw_count;
  logic                         r_lockup_err;
  logic                         w_seed_hit;
  logic                         w_step;
  logic                         w_draw_inc;
  logic [NUM_NODES-1:0]         w_load;
  logic [NUM_NODES-1:0]         w_zero_det;
  logic [NUM_NODES*RNG_LEN-1:0] w_lane_flat;
  logic                         w_unused_lsbs;

  // Seeds aimed past the last lane are dropped as if never presented.
  assign w_seed_hit = seed_valid && ({1'b0, seed_lane} < NUM_NODES_W);

  always_comb begin
    w_fsm_next  = r_fsm;
    w_warm_next = r_warm_cnt;
    w_step      = 1'b0;
    w_draw_inc  = 1'b0;
    if (w_seed_hit) begin
      // A reseed pre-empts any transfer in the same cycle.
      w_fsm_next  = WARMUP;
      w_warm_next = WARM_INIT;
    end else begin
      case (r_fsm)
        WARMUP: begin
          if (r_warm_cnt == '0) begin
            w_fsm_next = RUN;
          end else begin
            w_step      = 1'b1;
            w_warm_next = r_warm_cnt - WARM_W'(1);
          end
        end
        RUN: begin
          if (rand_ready) begin
            w_step     = 1'b1;
            w_draw_inc = 1'b1;
          end
        end
        default: w_fsm_next = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= WARMUP;
      r_warm_cnt   <= WARM_INIT;
      r_draw_count <= 16'd0;
      r_lockup_err <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_warm_cnt <= w_warm_next;
      if (w_draw_inc && (r_draw_count != 16'hFFFF)) begin
        r_draw_count <= r_draw_count + 16'd1;
      end
      if (|w_zero_det) begin
        r_lockup_err <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_lane
    assign w_load[gi] = w_seed_hit && (seed_lane == LANE_W'(gi));

    lfsr_lane #(
      .RNG_LEN    (RNG_LEN),
      .TAP_MASK   (TAP_MASK),
      .RESET_SEED (DEFAULT_SEED + RNG_LEN'(gi))
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[gi]),
      .load_val (seed_data),
      .step     (w_step),
      .state    (w_lane_flat[gi*RNG_LEN +: RNG_LEN]),
      .zero_det (w_zero_det[gi])
    );

    assign rand_data[gi*P_OUT +: P_OUT] = w_lane_flat[gi*RNG_LEN + RNG_LEN - 1 -: P_OUT];
  end

  // Low state bits only feed each lane's own next-state logic.
  assign w_unused_lsbs = ^w_lane_flat;

  assign rand_valid = (r_fsm == RUN);
  assign draw_count = r_draw_count;
  assign lockup_err = r_lockup_err;

endmodule
